// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared encodings for the multi-cycle MIPS control path:
//             opcodes, R-type function codes, ALU control words and the
//             controller state encodings S0..S11.
//  Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU control words
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    // Unknown function: the ALU produces 0 for this code
    localparam logic [3:0] ALU_NOP = 4'b1111;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // PCSrc selects
    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Controller states; codes 12..15 are illegal and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decoder
//  Purpose  : Combinational R-type function-code to ALUControl translation.
//             Unrecognised function codes map to the "produce zero" code so
//             that the write-back still happens, but with a result of 0.
//  Revision : 1.0  initial release
// ============================================================================
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o
);

    // Map the function field onto the ALU operation it requests
    always_comb begin
        alu_ctrl_o = ALU_NOP;
        case (funct_i)
            FUNCT_ADD: alu_ctrl_o = ALU_ADD;
            FUNCT_SUB: alu_ctrl_o = ALU_SUB;
            FUNCT_AND: alu_ctrl_o = ALU_AND;
            FUNCT_OR:  alu_ctrl_o = ALU_OR;
            FUNCT_SLT: alu_ctrl_o = ALU_SLT;
            default:   alu_ctrl_o = ALU_NOP;
        endcase
    end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mips_multicycle_ctrl
//  Purpose  : Moore control FSM for the multi-cycle MIPS datapath. Sequences
//             fetch / decode / execute / memory / write-back and drives every
//             datapath mux select, write enable and the ALUControl word.
//             Outputs are decoded from the current state; Funct is consulted
//             only in EXECUTE and Zero only in BRANCH.
//  Revision : 1.0  initial release
// ============================================================================
module mips_multicycle_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [3:0] ALUControl,
    output logic [3:0] state_o
);

    state_t     state_q;
    state_t     state_d;

    logic [3:0] funct_alu;

    // Raw per-state decode, before the reset gating of the enables
    logic       pcwrite;
    logic       branch;
    logic       irwrite_raw;
    logic       memwrite_raw;
    logic       regwrite_raw;

    alu_decoder u_alu_decoder (
        .funct_i    (funct_alu_src()),
        .alu_ctrl_o (funct_alu)
    );

    // Funct is only meaningful in EXECUTE; pass it straight through
    function automatic logic [5:0] funct_alu_src();
        return Funct;
    endfunction

    // State register; asynchronous clear puts the machine in FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection from the current state and the held opcode
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW,
                    OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE: state_d = S_EXECUTE;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_ADDI:  state_d = S_ADDIEX;
                    OP_J:     state_d = S_JUMP;
                    // Unsupported opcode: drop it and refetch
                    default:  state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDIEX:   state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Per-state output decode; anything not set for a state stays 0
    always_comb begin
        IorD         = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        regwrite_raw = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_B;
        PCSrc        = PCSRC_ALURES;
        ALUControl   = ALU_ADD;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB     = SRCB_FOUR;
                irwrite_raw = 1'b1;
                pcwrite     = 1'b1;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut
                ALUSrcB = SRCB_IMMSH2;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                IorD = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_MEMWRITE: begin
                IorD         = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu;
            end
            S_ALUWB: begin
                RegDst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = PCSRC_ALUOUT;
                branch     = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDIWB: begin
                regwrite_raw = 1'b1;
            end
            S_JUMP: begin
                PCSrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: begin
                // Illegal encoding: everything at its idle value
                ALUControl = ALU_ADD;
            end
        endcase
    end

    // Enables are gated by reset so nothing is written while rst_n is low,
    // including the moment reset is asserted mid-instruction
    always_comb begin
        IRWrite  = irwrite_raw  & rst_n;
        MemWrite = memwrite_raw & rst_n;
        RegWrite = regwrite_raw & rst_n;
        PCEn     = (pcwrite | (branch & Zero)) & rst_n;
    end

    assign state_o = state_q;

endmodule : mips_multicycle_ctrl
`default_nettype wire
